// File: rtl/uart_alu_ctrl.sv
// Command packet sequencer between UART rx and tx byte streams: echo, 32-bit add, optional multiply (UART_ALU_MUL_EN).
// Result rises 1 cycle after the last operand byte; one tx byte in flight, rx stalls while a response is pending.
module uart_alu_ctrl #(
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] rx_tdata_i,
   input  logic                  rx_tvalid_i,
   output logic                  rx_tready_o,
   output logic [DATA_WIDTH-1:0] tx_tdata_o,
   output logic                  tx_tvalid_o,
   input  logic                  tx_tready_i,
   output logic                  busy_o,
   output logic                  err_o,
   output logic [1:0]            err_code_o
);

   localparam logic [7:0] OP_ECHO = 8'hEC;
   localparam logic [7:0] OP_ADD  = 8'hAD;
   localparam int         TW      = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_RSV, S_LEN_LO, S_LEN_HI, S_ECHO, S_OPND, S_MUL, S_RESP, S_DRAIN
   } state_t;

   state_t        state, nxt;
   logic [7:0]    opcode;
   logic [7:0]    len_lo;
   logic [15:0]   cnt;
   logic [31:0]   acc;
   logic [23:0]   opnd_sr;
   logic [1:0]    byte_idx;
   logic [1:0]    resp_idx;
   logic          first_op;
   logic [TW-1:0] tmo_cnt;

   logic          rx_fire, tx_fire, tmo_run, tmo_hit, hdr_done;
   logic          is_mul, op_echo, op_arith, op_bad, len_short, arith_len_bad;
   logic [15:0]   len_new, drain_len;
   logic [31:0]   operand, acc_load;
   logic [1:0]    resp_nxt;
   logic          opnd_done, err_set;
   logic [1:0]    err_val;

   assign rx_fire   = rx_tvalid_i && rx_tready_o;
   assign tx_fire   = tx_tvalid_o && tx_tready_i;
   assign tmo_hit   = tmo_run && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign hdr_done  = (state == S_LEN_HI) && rx_fire;

   assign len_new   = {rx_tdata_i, len_lo};
   assign drain_len = len_new - 16'd4;
   assign op_echo   = (opcode == OP_ECHO);
`ifdef UART_ALU_MUL_EN
   assign is_mul    = (opcode == 8'hB0);
`else
   assign is_mul    = 1'b0;
`endif
   assign op_arith      = (opcode == OP_ADD) || is_mul;
   assign op_bad        = !op_echo && !op_arith;
   assign len_short     = (len_new < 16'd4);
   assign arith_len_bad = op_arith && ((len_new < 16'd8) || (len_new[1:0] != 2'b00));

   // Operands arrive LSB first; the fourth byte completes the word combinationally
   assign operand   = {rx_tdata_i, opnd_sr};
   assign acc_load  = first_op ? operand : acc + operand;
   assign opnd_done = (state == S_OPND) && rx_fire && (byte_idx == 2'd3);
   assign resp_nxt  = resp_idx + 2'd1;

`ifdef UART_ALU_MUL_EN
   logic [31:0] mcand, mplier, mul_step;
   logic [4:0]  mul_cnt;
   assign mul_step = acc + (mplier[0] ? mcand : 32'd0);
`endif

   always_comb begin
      err_set = 1'b0;
      err_val = 2'd0;
      if (tmo_hit) begin
         err_set = 1'b1;
         err_val = 2'd3;
      end else if (hdr_done) begin
         if (op_bad) begin
            err_set = 1'b1;
            err_val = 2'd1;
         end else if (len_short || arith_len_bad) begin
            err_set = 1'b1;
            err_val = 2'd2;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      if (tmo_hit) begin
         nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:   if (rx_fire) nxt = S_RSV;
            S_RSV:    if (rx_fire) nxt = S_LEN_LO;
            S_LEN_LO: if (rx_fire) nxt = S_LEN_HI;
            S_LEN_HI: begin
               if (rx_fire) begin
                  if (op_bad || (!len_short && arith_len_bad))
                     nxt = (len_new > 16'd4) ? S_DRAIN : S_IDLE;
                  else if (len_short || len_new == 16'd4)
                     nxt = S_IDLE;
                  else if (op_echo)
                     nxt = S_ECHO;
                  else
                     nxt = S_OPND;
               end
            end
            S_ECHO:   if (tx_fire && cnt == 16'd0) nxt = S_IDLE;
            S_OPND: begin
               if (opnd_done) begin
                  if (is_mul && !first_op) nxt = S_MUL;
                  else if (cnt == 16'd1)   nxt = S_RESP;
               end
            end
`ifdef UART_ALU_MUL_EN
            S_MUL:    if (mul_cnt == 5'd31) nxt = (cnt == 16'd0) ? S_RESP : S_OPND;
`endif
            S_RESP:   if (tx_fire && resp_idx == 2'd3) nxt = S_IDLE;
            S_DRAIN:  if (rx_fire && cnt == 16'd1) nxt = S_IDLE;
            default:  nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      rx_tready_o = 1'b0;
      tmo_run     = 1'b0;
      busy_o      = (state != S_IDLE);
      case (state)
         S_IDLE: rx_tready_o = 1'b1;
         S_RSV, S_LEN_LO, S_LEN_HI, S_OPND, S_DRAIN: begin
            rx_tready_o = 1'b1;
            tmo_run     = 1'b1;
         end
         S_ECHO: begin
            rx_tready_o = !tx_tvalid_o;
            tmo_run     = !tx_tvalid_o;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opcode      <= '0;
         len_lo      <= '0;
         cnt         <= '0;
         acc         <= '0;
         opnd_sr     <= '0;
         byte_idx    <= '0;
         resp_idx    <= '0;
         first_op    <= 1'b0;
         tmo_cnt     <= '0;
         tx_tdata_o  <= '0;
         tx_tvalid_o <= 1'b0;
         err_o       <= 1'b0;
         err_code_o  <= '0;
`ifdef UART_ALU_MUL_EN
         mcand       <= '0;
         mplier      <= '0;
         mul_cnt     <= '0;
`endif
      end else begin
         err_o <= err_set;
         if (err_set) err_code_o <= err_val;

         if (!tmo_run || rx_fire || tmo_hit) tmo_cnt <= '0;
         else                                tmo_cnt <= tmo_cnt + 1'b1;

         // A timeout wins over a byte landing in the same cycle
         if (tmo_hit) begin
            acc         <= '0;
            tx_tvalid_o <= 1'b0;
         end else begin
            case (state)
               S_IDLE:   if (rx_fire) opcode <= rx_tdata_i;
               S_LEN_LO: if (rx_fire) len_lo <= rx_tdata_i;
               S_LEN_HI: begin
                  if (rx_fire) begin
                     cnt      <= drain_len;
                     byte_idx <= '0;
                     first_op <= 1'b1;
                  end
               end
               S_ECHO: begin
                  if (rx_fire) begin
                     tx_tdata_o  <= rx_tdata_i;
                     tx_tvalid_o <= 1'b1;
                     cnt         <= cnt - 16'd1;
                  end else if (tx_fire) begin
                     tx_tvalid_o <= 1'b0;
                  end
               end
               S_OPND: begin
                  if (rx_fire) begin
                     opnd_sr  <= {rx_tdata_i, opnd_sr[23:8]};
                     byte_idx <= byte_idx + 2'd1;
                     cnt      <= cnt - 16'd1;
                     if (byte_idx == 2'd3) begin
                        first_op <= 1'b0;
                        if (is_mul && !first_op) begin
`ifdef UART_ALU_MUL_EN
                           mcand   <= acc;
                           mplier  <= operand;
                           mul_cnt <= '0;
`endif
                           acc     <= '0;
                        end else begin
                           acc <= acc_load;
                           if (cnt == 16'd1) begin
                              tx_tdata_o  <= acc_load[7:0];
                              tx_tvalid_o <= 1'b1;
                              resp_idx    <= '0;
                           end
                        end
                     end
                  end
               end
`ifdef UART_ALU_MUL_EN
               S_MUL: begin
                  acc     <= mul_step;
                  mcand   <= mcand << 1;
                  mplier  <= mplier >> 1;
                  mul_cnt <= mul_cnt + 5'd1;
                  if (mul_cnt == 5'd31 && cnt == 16'd0) begin
                     tx_tdata_o  <= mul_step[7:0];
                     tx_tvalid_o <= 1'b1;
                     resp_idx    <= '0;
                  end
               end
`endif
               S_RESP: begin
                  if (tx_fire) begin
                     if (resp_idx == 2'd3) begin
                        tx_tvalid_o <= 1'b0;
                     end else begin
                        resp_idx   <= resp_nxt;
                        tx_tdata_o <= acc[{resp_nxt, 3'b000} +: 8];
                     end
                  end
               end
               S_DRAIN: if (rx_fire) cnt <= cnt - 16'd1;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl: add, wrap, echo under tx stall, error paths, timeout, multiply/reset.
module tb_uart_alu_ctrl;
   localparam int TMO = 50;
   typedef logic [7:0] bytes_t [$];

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_tdata;
   logic       rx_tvalid;
   logic       rx_tready;
   logic [7:0] tx_tdata;
   logic       tx_tvalid;
   logic       tx_tready;
   logic       busy, err_o;
   logic [1:0] err_code;

   int     checks = 0;
   int     errors = 0;
   int     err_pulses = 0;
   bytes_t tx_q;

   always #5 clk = ~clk;

   uart_alu_ctrl #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .rx_tdata_i(rx_tdata), .rx_tvalid_i(rx_tvalid), .rx_tready_o(rx_tready),
      .tx_tdata_o(tx_tdata), .tx_tvalid_o(tx_tvalid), .tx_tready_i(tx_tready),
      .busy_o(busy), .err_o(err_o), .err_code_o(err_code)
   );

   // Inputs change 1ns after posedge, so a negedge view is what the next edge captures
   always @(negedge clk) begin
      if (rst_n && tx_tvalid && tx_tready) tx_q.push_back(tx_tdata);
      if (rst_n && err_o) err_pulses++;
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      rx_tdata  = b;
      rx_tvalid = 1'b1;
      @(negedge clk);
      while (!rx_tready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!rx_tready) begin
         checks++;
         errors++;
         $display("FAIL send_byte %h: rx_tready never rose within 1000 cycles", b);
      end
      @(posedge clk);
      #1;
      rx_tvalid = 1'b0;
   endtask

   task automatic send_bytes(input bytes_t pkt);
      foreach (pkt[i]) send_byte(pkt[i]);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle: busy got %b want 0 after 2000 cycles", name, busy);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (tx_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", tx_tvalid); end
      checks++; if (tx_tdata !== 8'h00) begin errors++; $display("FAIL rst_tdata got %h want 00", tx_tdata); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err_o); end
      checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL rst_code got %0d want 0", err_code); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (rx_tready !== 1'b1) begin errors++; $display("FAIL rst_rdy got %b want 1", rx_tready); end
   endtask

   task automatic test_add;
      bytes_t pkt, hdr;
      tx_q.delete();
      err_pulses = 0;
      hdr = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00};
      send_bytes(hdr);
      send_byte(8'h00);
      checks++;
      if (tx_tvalid !== 1'b1 || tx_tdata !== 8'h03) begin
         errors++;
         $display("FAIL add_latency: vld/dat got %b/%h want 1/03", tx_tvalid, tx_tdata);
      end
      wait_idle("add");
      pkt = '{8'h03, 8'h00, 8'h00, 8'h00};
      checks++; if (tx_q != pkt) begin errors++; $display("FAIL add_result got %p want %p", tx_q, pkt); end
      checks++; if (err_pulses != 0) begin errors++; $display("FAIL add_err pulses got %0d want 0", err_pulses); end
   endtask

   task automatic test_add_wrap;
      bytes_t pkt;
      tx_q.delete();
      pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
      send_bytes(pkt);
      wait_idle("wrap");
      pkt = '{8'h01, 8'h00, 8'h00, 8'h00};
      checks++; if (tx_q != pkt) begin errors++; $display("FAIL add_wrap got %p want %p", tx_q, pkt); end
   endtask

   task automatic test_echo_stall;
      bytes_t pkt, payload;
      tx_q.delete();
      tx_tready = 1'b0;
      pkt = '{8'hEC, 8'h00, 8'h07, 8'h00};
      payload = '{8'h41, 8'h42, 8'h43};
      send_bytes(pkt);
      foreach (payload[i]) begin
         int bad = 0;
         send_byte(payload[i]);
         for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (tx_tvalid !== 1'b1 || tx_tdata !== payload[i] || rx_tready !== 1'b0) bad++;
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL echo_hold byte %h: %0d stalled cycles changed, last vld/dat %b/%h", payload[i], bad, tx_tvalid, tx_tdata);
         end
         @(posedge clk); #1; tx_tready = 1'b1;
         @(posedge clk); #1; tx_tready = 1'b0;
      end
      tx_tready = 1'b1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL echo_done busy got %b want 0", busy); end
      checks++; if (tx_q != payload) begin errors++; $display("FAIL echo_data got %p want %p", tx_q, payload); end
   endtask

   task automatic test_echo_empty;
      bytes_t pkt;
      tx_q.delete();
      err_pulses = 0;
      pkt = '{8'hEC, 8'h00, 8'h04, 8'h00};
      send_bytes(pkt);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL echo_empty busy got %b want 0", busy); end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (tx_q.size() != 0 || err_pulses != 0) begin
         errors++;
         $display("FAIL echo_empty tx bytes %0d err pulses %0d want 0/0", tx_q.size(), err_pulses);
      end
   endtask

   task automatic test_bad_opcode;
      bytes_t pkt;
      tx_q.delete();
      err_pulses = 0;
      pkt = '{8'h55, 8'h00, 8'h06, 8'h00};
      send_bytes(pkt);
      checks++;
      if (err_o !== 1'b1 || err_code !== 2'd1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL badop_flag err/code/busy got %b/%0d/%b want 1/1/1", err_o, err_code, busy);
      end
      pkt = '{8'hAA, 8'hBB};
      send_bytes(pkt);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badop_drain busy got %b want 0", busy); end
      pkt = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
      send_bytes(pkt);
      wait_idle("badop");
      pkt = '{8'h05, 8'h00, 8'h00, 8'h00};
      checks++; if (tx_q != pkt) begin errors++; $display("FAIL badop_next got %p want %p", tx_q, pkt); end
      checks++;
      if (err_pulses != 1 || err_code !== 2'd1) begin
         errors++;
         $display("FAIL badop_count pulses/code got %0d/%0d want 1/1", err_pulses, err_code);
      end
   endtask

   task automatic test_bad_length;
      bytes_t pkt;
      tx_q.delete();
      err_pulses = 0;
      pkt = '{8'hAD, 8'h00, 8'h09, 8'h00};
      send_bytes(pkt);
      checks++;
      if (err_o !== 1'b1 || err_code !== 2'd2 || busy !== 1'b1) begin
         errors++;
         $display("FAIL badlen_flag err/code/busy got %b/%0d/%b want 1/2/1", err_o, err_code, busy);
      end
      pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      send_bytes(pkt);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badlen_drain busy got %b want 0", busy); end
      pkt = '{8'hAD, 8'h00, 8'h02, 8'h00};
      send_bytes(pkt);
      checks++;
      if (err_o !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0) begin
         errors++;
         $display("FAIL badlen_short err/code/busy got %b/%0d/%b want 1/2/0", err_o, err_code, busy);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (tx_q.size() != 0 || err_pulses != 2) begin
         errors++;
         $display("FAIL badlen_tx bytes/pulses got %0d/%0d want 0/2", tx_q.size(), err_pulses);
      end
   endtask

   task automatic test_timeout;
      bytes_t pkt;
      int n = 0;
      tx_q.delete();
      pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01};
      send_bytes(pkt);
      while (!err_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n < TMO - 1 || n > TMO + 3) begin
         errors++;
         $display("FAIL tmo_delay got %0d idle cycles want about %0d", n, TMO + 1);
      end
      checks++;
      if (err_code !== 2'd3 || busy !== 1'b0) begin
         errors++;
         $display("FAIL tmo_state code/busy got %0d/%b want 3/0", err_code, busy);
      end
      @(posedge clk);
      #1;
      pkt = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
      send_bytes(pkt);
      wait_idle("tmo");
      pkt = '{8'h07, 8'h00, 8'h00, 8'h00};
      checks++; if (tx_q != pkt) begin errors++; $display("FAIL tmo_recover got %p want %p", tx_q, pkt); end
   endtask

   task automatic test_mul;
      bytes_t pkt;
      tx_q.delete();
      pkt = '{8'hB0, 8'h00, 8'h0C, 8'h00};
      send_bytes(pkt);
`ifdef UART_ALU_MUL_EN
      pkt = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
      send_bytes(pkt);
      wait_idle("mul");
      pkt = '{8'h0F, 8'h00, 8'h00, 8'h00};
      checks++; if (tx_q != pkt) begin errors++; $display("FAIL mul_result got %p want %p", tx_q, pkt); end
`else
      checks++;
      if (err_o !== 1'b1 || err_code !== 2'd1) begin
         errors++;
         $display("FAIL mul_off err/code got %b/%0d want 1/1", err_o, err_code);
      end
      pkt = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
      send_bytes(pkt);
      checks++;
      if (busy !== 1'b0 || tx_q.size() != 0) begin
         errors++;
         $display("FAIL mul_off_drain busy/tx got %b/%0d want 0/0", busy, tx_q.size());
      end
`endif
   endtask

   task automatic test_reset_mid;
      bytes_t pkt;
      tx_tready = 1'b0;
      pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
      send_bytes(pkt);
      checks++;
      if (tx_tvalid !== 1'b1 || tx_tdata !== 8'h0A) begin
         errors++;
         $display("FAIL mid_resp vld/dat got %b/%h want 1/0a", tx_tvalid, tx_tdata);
      end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (tx_tvalid !== 1'b0 || tx_tdata !== 8'h00 || busy !== 1'b0 || err_code !== 2'd0) begin
         errors++;
         $display("FAIL mid_reset vld/dat/busy/code got %b/%h/%b/%0d want 0/00/0/0", tx_tvalid, tx_tdata, busy, err_code);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tx_tready = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rx_tdata  = 8'h00;
      rx_tvalid = 1'b0;
      tx_tready = 1'b1;
      test_reset;
      test_add;
      test_add_wrap;
      test_echo_stall;
      test_echo_empty;
      test_bad_opcode;
      test_bad_length;
      test_timeout;
      test_mul;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
